// File: rtl/iir_biquad_mac_sched.sv
// Direct-form-I biquad evaluated on one shared, pipelined Q2.22 multiplier.
// Five products are issued back-to-back, the in-order returns are accumulated, and the saturated y is emitted.
module iir_biquad_mac_sched #(
    parameter int DW        = 24,
    parameter int ACC_W     = 27,
    parameter int NUM_TERMS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] y_out,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic          cfg_err,
    input  logic          clr_hist,
    output logic          mul_valid,
    output logic [DW-1:0] mul_a,
    output logic [DW-1:0] mul_b,
    input  logic          mul_vout,
    input  logic [DW-1:0] mul_p
);

    localparam int CW    = $clog2(NUM_TERMS + 1);
    localparam int N_ADD = 3;  // b0..b2 products add, a1..a2 products subtract

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                   state;
    logic [DW-1:0]            coef [NUM_TERMS];
    logic [DW-1:0]            x, x1, x2, y1, y2;
    logic signed [ACC_W-1:0]  acc;
    logic [CW-1:0]            issue_k;
    logic [CW-1:0]            ret_cnt;

    logic                     cfg_ok;
    logic [DW-1:0]            b0_eff;
    logic                     ret_take;
    logic                     last_ret;
    logic signed [ACC_W-1:0]  p_ext;
    logic signed [ACC_W-1:0]  acc_next;

    function automatic logic [DW-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > ACC_MAX)      sat = ACC_MAX[DW-1:0];
        else if (a < ACC_MIN) sat = ACC_MIN[DW-1:0];
        else                  sat = a[DW-1:0];
    endfunction

    assign cfg_ok = cfg_we && (state == IDLE) && (cfg_addr < 3'(NUM_TERMS));
    // A b0 write in the accept cycle is forwarded so the whole sample sees one coefficient set.
    assign b0_eff = (cfg_ok && cfg_addr == 3'd0) ? cfg_data : coef[0];

    // Returns are only real once the first operand pair has been sampled by the multiplier.
    assign ret_take = mul_vout && ((state == ISSUE && issue_k != '0) || state == WAIT);
    assign last_ret = ret_take && (ret_cnt == CW'(NUM_TERMS - 1));
    assign p_ext    = ACC_W'($signed(mul_p));
    assign acc_next = (ret_cnt < CW'(N_ADD)) ? acc + p_ext : acc - p_ext;

    // NOTE: every register here updates with <= so all reads within a clock see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y_out     <= '0;
            cfg_err   <= 1'b0;
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            // NOTE: the coefficient file is reset explicitly; a reset must leave a known all-zero filter.
            for (int i = 0; i < NUM_TERMS; i++) coef[i] <= '0;
            x         <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            acc       <= '0;
            issue_k   <= '0;
            ret_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;

            if (cfg_we) begin
                if (cfg_ok) coef[cfg_addr] <= cfg_data;
                else        cfg_err        <= 1'b1;
            end

            if (ret_take) begin
                acc     <= acc_next;
                ret_cnt <= ret_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clr_hist) begin
                        x1 <= '0;
                        x2 <= '0;
                        y1 <= '0;
                        y2 <= '0;
                    end
                    if (in_valid) begin
                        x         <= in_data;
                        state     <= ISSUE;
                        in_ready  <= 1'b0;
                        mul_valid <= 1'b1;
                        mul_a     <= b0_eff;
                        mul_b     <= in_data;
                        issue_k   <= '0;
                    end
                end

                ISSUE: begin
                    if (issue_k == CW'(NUM_TERMS - 1)) begin
                        mul_valid <= 1'b0;
                        mul_a     <= '0;
                        mul_b     <= '0;
                        state     <= WAIT;
                    end else begin
                        issue_k <= issue_k + 1'b1;
                        case (issue_k)
                            CW'(0):  begin mul_a <= coef[1]; mul_b <= x1; end
                            CW'(1):  begin mul_a <= coef[2]; mul_b <= x2; end
                            CW'(2):  begin mul_a <= coef[3]; mul_b <= y1; end
                            default: begin mul_a <= coef[4]; mul_b <= y2; end
                        endcase
                    end
                end

                WAIT: begin
                    if (last_ret) begin
                        y_out     <= sat(acc_next);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    x2       <= x1;
                    x1       <= x;
                    y2       <= y1;
                    y1       <= y_out;
                    acc      <= '0;
                    ret_cnt  <= '0;
                    issue_k  <= '0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_mac_sched.sv
// Directed bench for iir_biquad_mac_sched: vector table plus hand-written timing, busy, clear and reset sequences.
// A behavioural 14-stage multiplier closes the loop so results return in cycle T+15..T+19.
module tb_iir_biquad_mac_sched;

    localparam int DW      = 24;
    localparam int MUL_LAT = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] y_out;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_err;
    logic          clr_hist = 1'b0;
    logic          mul_valid;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_vout;
    logic [DW-1:0] mul_p;

    logic          inject = 1'b0;
    logic [DW-1:0] inject_p = '0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    iir_biquad_mac_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .y_out     (y_out),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .clr_hist  (clr_hist),
        .mul_valid (mul_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_vout  (mul_vout),
        .mul_p     (mul_p)
    );

    // Shared multiplier: Q2.22 x Q2.22 -> Q2.22, truncated, fixed latency, reset by rst_n.
    logic signed [2*DW-1:0] full_prod;
    logic [MUL_LAT-1:0]     pv;
    logic [DW-1:0]          pp [MUL_LAT];

    always_comb full_prod = $signed(mul_a) * $signed(mul_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < MUL_LAT; i++) pp[i] <= '0;
        end else begin
            pv    <= {pv[MUL_LAT-2:0], mul_valid};
            pp[0] <= full_prod[2*DW-3:DW-2];
            for (int i = 1; i < MUL_LAT; i++) pp[i] <= pp[i-1];
        end
    end

    assign mul_vout = pv[MUL_LAT-1] | inject;
    assign mul_p    = inject ? inject_p : pp[MUL_LAT-1];

    typedef struct {
        logic          ld;
        logic [DW-1:0] b0, b1, b2, a1, a2;
        logic          clr;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [DW-1:0] data, input logic exp_err);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
        check($sformatf("cfg_err addr%0d", addr), cfg_err, exp_err);
    endtask

    task automatic load_coefs(input logic [DW-1:0] b0, b1, b2, a1, a2);
        cfg_write(3'd0, b0, 1'b0);
        cfg_write(3'd1, b1, 1'b0);
        cfg_write(3'd2, b2, 1'b0);
        cfg_write(3'd3, a1, 1'b0);
        cfg_write(3'd4, a2, 1'b0);
    endtask

    task automatic run_sample(input logic [DW-1:0] x, input logic clr, input string name,
                              input logic [DW-1:0] y_exp);
        bit found = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        clr_hist = clr;
        @(negedge clk);
        in_valid = 1'b0;
        clr_hist = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check({name, " timeout"}, 32'd0, 32'd1);
        else        check(name, y_out, y_exp);
        @(negedge clk);
    endtask

    initial begin
        bit found;

        tbl[0]  = '{1'b1, 24'h400000, 24'h000000, 24'h000000, 24'hE00000, 24'h000000, 1'b1, 24'h400000, 24'h400000};
        tbl[1]  = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h000000, 24'h200000};
        tbl[2]  = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h000000, 24'h100000};
        tbl[3]  = '{1'b1, 24'h400000, 24'h400000, 24'h400000, 24'h000000, 24'h000000, 1'b1, 24'h600000, 24'h600000};
        tbl[4]  = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h600000, 24'h7FFFFF};
        tbl[5]  = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h600000, 24'h7FFFFF};
        tbl[6]  = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b1, 24'hA00000, 24'hA00000};
        tbl[7]  = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'hA00000, 24'h800000};
        tbl[8]  = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'hA00000, 24'h800000};
        tbl[9]  = '{1'b1, 24'h400000, 24'h200000, 24'h100000, 24'h000000, 24'h200000, 1'b1, 24'h400000, 24'h400000};
        tbl[10] = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h000000, 24'h200000};
        tbl[11] = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h000000, 24'hF00000};
        tbl[12] = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h000000, 24'hF00000};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst y_out", y_out, 0);
        check("rst mul_valid", mul_valid, 0);
        check("rst mul_a", mul_a, 0);
        check("rst mul_b", mul_b, 0);
        check("rst cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        // Out-of-range addresses are rejected even when idle.
        cfg_write(3'd5, 24'h123456, 1'b1);
        cfg_write(3'd7, 24'h123456, 1'b1);

        // Pass-through with cycle-exact timing; a bogus return in the first issue cycle must be ignored.
        load_coefs(24'h400000, 24'h0, 24'h0, 24'h0, 24'h0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 24'h200000;
        clr_hist = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (i == 1) begin
                in_valid = 1'b0;
                clr_hist = 1'b0;
                inject   = 1'b1;
                inject_p = 24'h3FFFFF;
                check("t1 mul_a", mul_a, 32'h400000);
                check("t1 mul_b", mul_b, 32'h200000);
            end else begin
                inject = 1'b0;
            end
            check($sformatf("T+%0d mul_valid", i), mul_valid, (i <= 5) ? 1 : 0);
            check($sformatf("T+%0d out_valid", i), out_valid, (i == 20) ? 1 : 0);
            check($sformatf("T+%0d in_ready", i), in_ready, (i >= 21) ? 1 : 0);
            if (i == 20) check("pass-through y", y_out, 32'h200000);
        end

        // Table-driven vectors: feedback impulse, saturation both ways, all five taps.
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].ld) load_coefs(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].a1, tbl[i].a2);
            run_sample(tbl[i].x, tbl[i].clr, $sformatf("vec%0d y", i), tbl[i].y);
        end

        // clr_hist on its own in IDLE wipes the nonzero y history left by the table.
        @(negedge clk);
        clr_hist = 1'b1;
        @(negedge clk);
        clr_hist = 1'b0;
        run_sample(24'h000000, 1'b0, "clr_hist y", 24'h000000);

        // Busy: sample and b0 write held through ISSUE/WAIT must be refused.
        load_coefs(24'h400000, 24'h0, 24'h0, 24'h0, 24'h0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 24'h200000;
        clr_hist = 1'b1;
        @(negedge clk);
        clr_hist = 1'b0;
        in_data  = 24'h7FFFFF;
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 24'h000000;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else begin
                check($sformatf("busy%0d in_ready", i), in_ready, 0);
                check($sformatf("busy%0d cfg_err", i), cfg_err, 1);
            end
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (!found) check("busy timeout", 32'd0, 32'd1);
        else        check("busy y", y_out, 32'h200000);
        repeat (4) @(negedge clk);
        check("busy after in_ready", in_ready, 1);
        check("busy after out_valid", out_valid, 0);
        run_sample(24'h200000, 1'b1, "b0 kept y", 24'h200000);

        // Stray return while idle must not leak into the next accumulation.
        @(negedge clk);
        inject   = 1'b1;
        inject_p = 24'h3FFFFF;
        @(negedge clk);
        inject = 1'b0;
        run_sample(24'h200000, 1'b1, "stray idle y", 24'h200000);

        // Reset in WAIT: everything returns to zero, including coefficients.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 24'h100000;
        clr_hist = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clr_hist = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst out_valid", out_valid, 0);
        check("midrst in_ready", in_ready, 1);
        check("midrst y_out", y_out, 0);
        check("midrst mul_valid", mul_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sample(24'h200000, 1'b0, "post-rst zero coef y", 24'h000000);
        load_coefs(24'h400000, 24'h0, 24'h0, 24'h0, 24'h0);
        run_sample(24'h200000, 1'b0, "post-rst pass y", 24'h200000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
